kmeans_centroid_update: RTL and testbench

KMEANS_CENTROID_UPDATE -- requirements
Module: kmeans_centroid_update

---
 rtl/kmeans_centroid_update_pkg.sv | 22 ++
 rtl/kmeans_centroid_update_if.sv | 40 ++++
 rtl/kmeans_centroid_update_div.sv | 60 ++++++
 rtl/kmeans_centroid_update.sv | 145 ++++++++++++++
 tb/tb_kmeans_centroid_update.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kmeans_centroid_update_pkg.sv
// Shared definitions for the two-cluster, two-dimension k-means centroid update:
// default widths and the controller state encoding.
package kmeans_centroid_update_pkg;

    localparam int DATA_WIDTH_DEF    = 16;
    localparam int ACC_SUM_WIDTH_DEF = 24;
    localparam int CNT_WIDTH_DEF     = 9;
    localparam int TOL_DEF           = 0;

    // Coordinates are processed in the order k0_0, k0_1, k1_0, k1_1.
    localparam int NUM_COORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        NEXT,
        CMP,
        DONE
    } state_t;

endpackage

// File: rtl/kmeans_centroid_update_if.sv
// Request/result bundle between the classification stage and the centroid update.
interface kmeans_centroid_update_if
    import kmeans_centroid_update_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH_DEF,
    parameter int acc_sum_width = ACC_SUM_WIDTH_DEF,
    parameter int cnt_width     = CNT_WIDTH_DEF
);
    logic                     start;
    logic [acc_sum_width-1:0] sum_k0_d0;
    logic [acc_sum_width-1:0] sum_k0_d1;
    logic [acc_sum_width-1:0] sum_k1_d0;
    logic [acc_sum_width-1:0] sum_k1_d1;
    logic [cnt_width-1:0]     cnt_k0;
    logic [cnt_width-1:0]     cnt_k1;
    logic [data_width-1:0]    k0_0;
    logic [data_width-1:0]    k0_1;
    logic [data_width-1:0]    k1_0;
    logic [data_width-1:0]    k1_1;
    logic [data_width-1:0]    k0_0_n;
    logic [data_width-1:0]    k0_1_n;
    logic [data_width-1:0]    k1_0_n;
    logic [data_width-1:0]    k1_1_n;
    logic                     up_centroids;
    logic                     converged;
    logic                     busy;

    modport master (
        output start, sum_k0_d0, sum_k0_d1, sum_k1_d0, sum_k1_d1, cnt_k0, cnt_k1,
               k0_0, k0_1, k1_0, k1_1,
        input  k0_0_n, k0_1_n, k1_0_n, k1_1_n, up_centroids, converged, busy
    );

    modport slave (
        input  start, sum_k0_d0, sum_k0_d1, sum_k1_d0, sum_k1_d1, cnt_k0, cnt_k1,
               k0_0, k0_1, k1_0, k1_1,
        output k0_0_n, k0_1_n, k1_0_n, k1_1_n, up_centroids, converged, busy
    );

endinterface

// File: rtl/kmeans_centroid_update_div.sv
// Unsigned restoring divider producing one quotient bit per clock; shared by
// all four coordinates of the centroid update.
module kmeans_serial_div #(
    parameter int dividend_width = 24,
    parameter int divisor_width  = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [dividend_width-1:0] dividend,
    input  logic [divisor_width-1:0]  divisor,
    output logic [dividend_width-1:0] quotient,
    output logic                      done
);
    localparam int step_width = $clog2(dividend_width + 1);
    localparam logic [step_width-1:0] last_step = step_width'(dividend_width - 1);

    logic [divisor_width:0]    rem_reg;
    logic [dividend_width-1:0] quo_reg;
    logic [divisor_width-1:0]  dvs_reg;
    logic [step_width-1:0]     step_reg;
    logic                      run_reg;

    logic [divisor_width:0] shifted;
    logic                   fits;

    // The remainder is always below the divisor, so its top bit is free to
    // receive the next dividend bit without overflow.
    assign shifted = {rem_reg[divisor_width-1:0], quo_reg[dividend_width-1]};
    assign fits    = shifted >= {1'b0, dvs_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            step_reg <= '0;
            run_reg  <= 1'b0;
        end else if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dvs_reg  <= divisor;
            step_reg <= '0;
            run_reg  <= 1'b1;
        end else if (run_reg) begin
            rem_reg  <= fits ? (shifted - {1'b0, dvs_reg}) : shifted;
            quo_reg  <= {quo_reg[dividend_width-2:0], fits};
            step_reg <= step_reg + 1'b1;
            if (step_reg == last_step) begin
                run_reg <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge retires the final bit, so the
    // quotient is complete on the following cycle.
    assign done     = run_reg && (step_reg == last_step);
    assign quotient = quo_reg;

endmodule

// File: rtl/kmeans_centroid_update.sv
// Computes new centroids (sum / count, saturated) for two clusters in two
// dimensions with one shared serial divider, then flags convergence.
module kmeans_centroid_update
    import kmeans_centroid_update_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH_DEF,
    parameter int acc_sum_width = ACC_SUM_WIDTH_DEF,
    parameter int cnt_width     = CNT_WIDTH_DEF,
    parameter int tol           = TOL_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    kmeans_centroid_update_if.slave bus
);
    localparam logic [acc_sum_width-1:0] quo_max =
        acc_sum_width'((64'd1 << data_width) - 64'd1);
    localparam logic [data_width-1:0] tol_val = data_width'(tol);

    state_t                   state_reg;
    logic [1:0]               idx_reg;
    logic [acc_sum_width-1:0] sum_reg [NUM_COORDS];
    logic [cnt_width-1:0]     cnt_reg [2];
    logic [data_width-1:0]    old_reg [NUM_COORDS];
    logic [data_width-1:0]    new_reg [NUM_COORDS];
    logic                     up_reg;
    logic                     conv_reg;
    logic                     busy_reg;

    logic [acc_sum_width-1:0] sum_in [NUM_COORDS];
    logic [data_width-1:0]    old_in [NUM_COORDS];
    logic [cnt_width-1:0]     divisor;
    logic [acc_sum_width-1:0] dividend;
    logic                     div_start;
    logic                     div_done;
    logic [acc_sum_width-1:0] div_quo;
    logic [data_width-1:0]    quo_sat;
    logic [NUM_COORDS-1:0]    within_tol;

    assign sum_in[0] = bus.sum_k0_d0;
    assign sum_in[1] = bus.sum_k0_d1;
    assign sum_in[2] = bus.sum_k1_d0;
    assign sum_in[3] = bus.sum_k1_d1;
    assign old_in[0] = bus.k0_0;
    assign old_in[1] = bus.k0_1;
    assign old_in[2] = bus.k1_0;
    assign old_in[3] = bus.k1_1;

    // Index bit 1 selects the cluster, hence its count.
    assign divisor   = cnt_reg[idx_reg[1]];
    assign dividend  = sum_reg[idx_reg];
    assign div_start = (state_reg == LOAD) && (divisor != '0);
    assign quo_sat   = (div_quo > quo_max) ? '1 : div_quo[data_width-1:0];

    generate
        for (genvar gi = 0; gi < NUM_COORDS; gi++) begin : g_coord
            logic [data_width-1:0] diff;
            assign diff = (new_reg[gi] >= old_reg[gi]) ? (new_reg[gi] - old_reg[gi])
                                                       : (old_reg[gi] - new_reg[gi]);
            assign within_tol[gi] = diff <= tol_val;
        end
    endgenerate

    kmeans_serial_div #(
        .dividend_width(acc_sum_width),
        .divisor_width (cnt_width)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(dividend),
        .divisor (divisor),
        .quotient(div_quo),
        .done    (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            up_reg    <= 1'b0;
            conv_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            cnt_reg[0] <= '0;
            cnt_reg[1] <= '0;
            for (int i = 0; i < NUM_COORDS; i++) begin
                sum_reg[i] <= '0;
                old_reg[i] <= '0;
                new_reg[i] <= '0;
            end
        end else begin
            up_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NUM_COORDS; i++) begin
                            sum_reg[i] <= sum_in[i];
                            old_reg[i] <= old_in[i];
                        end
                        cnt_reg[0] <= bus.cnt_k0;
                        cnt_reg[1] <= bus.cnt_k1;
                        idx_reg    <= '0;
                        conv_reg   <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: state_reg <= (divisor == '0) ? NEXT : DIV;
                DIV: begin
                    if (div_done) begin
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    // An empty cluster keeps its previous centroid.
                    new_reg[idx_reg] <= (divisor == '0) ? old_reg[idx_reg] : quo_sat;
                    if (idx_reg == 2'd3) begin
                        state_reg <= CMP;
                    end else begin
                        idx_reg   <= idx_reg + 2'd1;
                        state_reg <= LOAD;
                    end
                end
                CMP: begin
                    conv_reg  <= &within_tol;
                    up_reg    <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.k0_0_n       = new_reg[0];
    assign bus.k0_1_n       = new_reg[1];
    assign bus.k1_0_n       = new_reg[2];
    assign bus.k1_1_n       = new_reg[3];
    assign bus.up_centroids = up_reg;
    assign bus.converged    = conv_reg;
    assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Bench for kmeans_centroid_update: two instances (tol 0 and tol 1) share
// stimulus and are checked every cycle against an arithmetic model.
module tb_kmeans_centroid_update;
    import kmeans_centroid_update_pkg::*;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kmeans_centroid_update_if #(.data_width(DW), .acc_sum_width(AW), .cnt_width(CW)) bus0 ();
    kmeans_centroid_update_if #(.data_width(DW), .acc_sum_width(AW), .cnt_width(CW)) bus1 ();

    kmeans_centroid_update #(.data_width(DW), .acc_sum_width(AW), .cnt_width(CW), .tol(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    kmeans_centroid_update #(.data_width(DW), .acc_sum_width(AW), .cnt_width(CW), .tol(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: quotient truncated, saturated, empty cluster keeps old value.
    function automatic int model_coord(input int s, input int c, input int o);
        int q;
        if (c == 0) return o;
        q = s / c;
        return (q > 65535) ? 65535 : q;
    endfunction

    bit armed = 0;
    bit run_valid = 0;
    bit bexp, uexp;
    int st_cyc = 0, done_cyc = 0;
    int exp_new[4];
    bit exp_conv[2];
    int held_n[4] = '{0, 0, 0, 0};
    bit held_conv[2] = '{0, 0};
    int up_cnt = 0, up_cyc = 0;
    logic [DW-1:0] o_n[2][4];
    logic up_o[2], conv_o[2], busy_o[2];

    always @(negedge clk) begin
        int s[4], c[2], old[4], lat, tv;
        bit ok;
        o_n[0][0] = bus0.k0_0_n; o_n[0][1] = bus0.k0_1_n; o_n[0][2] = bus0.k1_0_n; o_n[0][3] = bus0.k1_1_n;
        o_n[1][0] = bus1.k0_0_n; o_n[1][1] = bus1.k0_1_n; o_n[1][2] = bus1.k1_0_n; o_n[1][3] = bus1.k1_1_n;
        up_o[0] = bus0.up_centroids; up_o[1] = bus1.up_centroids;
        conv_o[0] = bus0.converged;  conv_o[1] = bus1.converged;
        busy_o[0] = bus0.busy;       busy_o[1] = bus1.busy;
        if (bus0.up_centroids === 1'b1) begin
            up_cnt++;
            up_cyc = cyc;
        end
        bexp = run_valid && (cyc > st_cyc) && (cyc <= done_cyc);
        uexp = run_valid && (cyc == done_cyc);
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[dut%0d]", d), 32'(busy_o[d]), 32'(bexp));
                chk($sformatf("up_centroids[dut%0d]", d), 32'(up_o[d]), 32'(uexp));
                for (int k = 0; k < 4; k++) begin
                    if (uexp)
                        chk($sformatf("new_centroid%0d[dut%0d]", k, d), 32'(o_n[d][k]), exp_new[k]);
                    else if (!bexp)
                        chk($sformatf("held_centroid%0d[dut%0d]", k, d), 32'(o_n[d][k]), held_n[k]);
                end
                if (uexp)
                    chk($sformatf("converged[dut%0d]", d), 32'(conv_o[d]), 32'(exp_conv[d]));
                else if (!bexp)
                    chk($sformatf("held_converged[dut%0d]", d), 32'(conv_o[d]), 32'(held_conv[d]));
            end
            if (uexp) begin
                held_n = exp_new;
                held_conv = exp_conv;
                run_valid = 0;
            end
        end
        if (rst) begin
            armed = 1;
            run_valid = 0;
            held_n = '{0, 0, 0, 0};
            held_conv = '{0, 0};
        end else if (armed && bus0.start && !bexp) begin
            s[0] = int'(bus0.sum_k0_d0); s[1] = int'(bus0.sum_k0_d1);
            s[2] = int'(bus0.sum_k1_d0); s[3] = int'(bus0.sum_k1_d1);
            c[0] = int'(bus0.cnt_k0);    c[1] = int'(bus0.cnt_k1);
            old[0] = int'(bus0.k0_0); old[1] = int'(bus0.k0_1);
            old[2] = int'(bus0.k1_0); old[3] = int'(bus0.k1_1);
            lat = 2;
            for (int k = 0; k < 4; k++) begin
                exp_new[k] = model_coord(s[k], c[k/2], old[k]);
                lat += (c[k/2] != 0) ? (AW + 2) : 2;
            end
            for (int d = 0; d < 2; d++) begin
                tv = d;
                ok = 1;
                for (int k = 0; k < 4; k++) begin
                    if (((exp_new[k] > old[k]) ? exp_new[k] - old[k] : old[k] - exp_new[k]) > tv) ok = 0;
                end
                exp_conv[d] = ok;
            end
            st_cyc = cyc;
            done_cyc = cyc + lat;
            run_valid = 1;
        end
    end

    task automatic drive(input int s00, input int s01, input int s10, input int s11,
                         input int c0, input int c1,
                         input int o00, input int o01, input int o10, input int o11);
        bus0.sum_k0_d0 = AW'(s00); bus0.sum_k0_d1 = AW'(s01);
        bus0.sum_k1_d0 = AW'(s10); bus0.sum_k1_d1 = AW'(s11);
        bus0.cnt_k0 = CW'(c0); bus0.cnt_k1 = CW'(c1);
        bus0.k0_0 = DW'(o00); bus0.k0_1 = DW'(o01); bus0.k1_0 = DW'(o10); bus0.k1_1 = DW'(o11);
        bus1.sum_k0_d0 = AW'(s00); bus1.sum_k0_d1 = AW'(s01);
        bus1.sum_k1_d0 = AW'(s10); bus1.sum_k1_d1 = AW'(s11);
        bus1.cnt_k0 = CW'(c0); bus1.cnt_k1 = CW'(c1);
        bus1.k0_0 = DW'(o00); bus1.k0_1 = DW'(o01); bus1.k1_0 = DW'(o10); bus1.k1_1 = DW'(o11);
    endtask

    task automatic set_start(input logic v);
        bus0.start = v;
        bus1.start = v;
    endtask

    // Pulses start, optionally re-pulses it extra cycles later, and returns the
    // cycle distance from the start cycle to the up_centroids cycle (-1 on timeout).
    task automatic run(input string tag, input int extra, output int lat);
        int t0, ups0;
        @(posedge clk); #1;
        set_start(1'b1);
        t0 = cyc;
        ups0 = up_cnt;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (up_cnt != ups0) begin
                lat = up_cyc - t0;
                break;
            end
            @(posedge clk); #1;
            set_start((extra > 0) && (cyc - t0 == extra));
        end
        set_start(1'b0);
        chk({tag, "_completed"}, 32'(lat != -1), 32'd1);
        $display("run %s: latency %0d, new (%0d,%0d) (%0d,%0d), converged tol0=%0b tol1=%0b",
                 tag, lat, bus0.k0_0_n, bus0.k0_1_n, bus0.k1_0_n, bus0.k1_1_n,
                 bus0.converged, bus1.converged);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, ups0, s[4], c[2], o[4];
        set_start(1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic division on both clusters.
        drive(30, 50, 700, 900, 10, 100, 0, 0, 1, 1);
        run("basic", 0, lat);
        chk("basic_latency", lat, 106);
        chk("basic_k0_0", 32'(bus0.k0_0_n), 3);
        chk("basic_k0_1", 32'(bus0.k0_1_n), 5);
        chk("basic_k1_0", 32'(bus0.k1_0_n), 7);
        chk("basic_k1_1", 32'(bus0.k1_1_n), 9);
        chk("basic_conv", 32'(bus0.converged), 0);
        idle(5);

        // Empty cluster 1 keeps its old centroid.
        drive(30, 50, 700, 900, 10, 0, 0, 0, 4, 6);
        run("empty_k1", 0, lat);
        chk("empty_latency", lat, 58);
        chk("empty_k0_0", 32'(bus0.k0_0_n), 3);
        chk("empty_k1_0", 32'(bus0.k1_0_n), 4);
        chk("empty_k1_1", 32'(bus0.k1_1_n), 6);
        idle(5);

        // Convergence with exact match, off-by-one and off-by-two.
        drive(40, 40, 40, 40, 10, 10, 4, 4, 4, 4);
        run("conv_exact", 0, lat);
        chk("conv_exact_tol0", 32'(bus0.converged), 1);
        chk("conv_exact_tol1", 32'(bus1.converged), 1);
        drive(40, 40, 40, 40, 10, 10, 4, 4, 4, 5);
        run("conv_off1", 0, lat);
        chk("conv_off1_tol0", 32'(bus0.converged), 0);
        chk("conv_off1_tol1", 32'(bus1.converged), 1);
        drive(40, 40, 40, 40, 10, 10, 4, 4, 4, 6);
        run("conv_off2", 0, lat);
        chk("conv_off2_tol1", 32'(bus1.converged), 0);
        idle(3);

        // Truncation, saturation and zero dividend.
        drive(7, 9, 24'hFFFFFF, 100, 2, 1, 0, 0, 0, 0);
        run("bounds_a", 0, lat);
        chk("trunc_7_2", 32'(bus0.k0_0_n), 3);
        chk("trunc_9_2", 32'(bus0.k0_1_n), 4);
        chk("saturate", 32'(bus0.k1_0_n), 32'hFFFF);
        drive(0, 25, 0, 0, 5, 511, 9, 9, 9, 9);
        run("bounds_b", 0, lat);
        chk("zero_dividend", 32'(bus0.k0_0_n), 0);
        chk("sum25_cnt5", 32'(bus0.k0_1_n), 5);
        idle(3);

        // A second start during a run is ignored.
        drive(30, 50, 700, 900, 10, 100, 0, 0, 1, 1);
        ups0 = up_cnt;
        run("double_start", 10, lat);
        idle(20);
        chk("double_start_latency", lat, 106);
        chk("double_start_pulses", up_cnt - ups0, 1);

        // Reset in the middle of a division.
        drive(1000, 2000, 3000, 4000, 7, 9, 1, 2, 3, 4);
        ups0 = up_cnt;
        @(posedge clk); #1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        idle(30);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #4;
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_k0_0", 32'(bus0.k0_0_n), 0);
        idle(150);
        chk("rst_no_pulse", up_cnt - ups0, 0);
        drive(30, 50, 700, 900, 10, 100, 0, 0, 1, 1);
        run("after_rst", 0, lat);
        chk("after_rst_latency", lat, 106);
        idle(3);

        // Random runs; old centroids often placed near the result to hit convergence.
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 4; k++)
                s[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24'hFFFFFF))
                                                   : int'($urandom_range(0, 5000));
            for (int k = 0; k < 2; k++)
                c[k] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 511));
            for (int k = 0; k < 4; k++) begin
                o[k] = model_coord(s[k], c[k/2], int'($urandom_range(0, 65535)));
                if ($urandom_range(0, 2) != 0) begin
                    o[k] = o[k] + int'($urandom_range(0, 2)) - 1;
                    if (o[k] < 0) o[k] = 0;
                    if (o[k] > 65535) o[k] = 65535;
                end else begin
                    o[k] = int'($urandom_range(0, 65535));
                end
            end
            drive(s[0], s[1], s[2], s[3], c[0], c[1], o[0], o[1], o[2], o[3]);
            run($sformatf("rand%0d", r), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0, lat);
            idle(int'($urandom_range(1, 4)));
        end

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
